sigmoid_rr_scheduler: RTL and testbench
=======================================

// Module: sigmoid_rr_scheduler
// PURPOSE
//   Shares one sigmoid_approx unit between N_REQ neuron requesters with round-robin arbitration.
//   One operation is in flight at a time, because the shared unit has no back-pressure and is iterative.
//   Input operands are held stable until the result is captured.
//   The result is returned tagged with the requester index. A watchdog guards a hung unit.
// PARAMETERS
//   N_REQ      4             number of requesters (>=2)
//   exp_width  8             FP exponent width
//   mant_width 24            FP mantissa width incl. hidden bit; W = exp_width+mant_width
//   TIMEOUT    64            max cycles in WAIT before the error return (>=2)
//   NAN_VAL    32'h7fc00000  data returned on timeout
// PORTS
//   clk            in   1            clock, rising edge
//   rst_l          in   1            reset, asynchronous, active-low
//   req_valid      in   N_REQ        per-requester operand valid
//   req_x          in   N_REQ*W      operand, requester i at [i*W +: W]
//   req_ready      out  N_REQ        one-hot grant/accept, IDLE only
//   resp_valid     out  1            result valid
//   resp_id        out  $clog2(N_REQ) requester index of the result
//   resp_data      out  W            sigmoid result (NAN_VAL on timeout)
//   resp_err       out  1            1 = timeout, result invalid
//   resp_ready     in   1            consumer accepts result
//   sig_in_x       out  W            to unit in_x; holds x_q from ISSUE through CAPT
//   sig_in_valid   out  1            to unit in_valid; single-cycle pulse
//   sig_out        in   W            from unit out_sigmoid (registered in the unit)
//   sig_out_valid  in   1            from unit out_valid
// BEHAVIOUR
//   Reset (async, rst_l=0):
//     state=IDLE; last_grant=N_REQ-1; cnt=0; x_q=0.
//     All outputs 0: req_ready, resp_*, sig_in_valid, sig_in_x.
//     The unit shares rst_l, so an in-flight op is discarded with no response.
//   FSM IDLE->ISSUE->WAIT->CAPT->RESP->IDLE (WAIT->RESP on timeout).
//   IDLE:
//     - grant g = first i with req_valid[i], searching last_grant+1, +2, ... mod N_REQ.
//     - req_ready=onehot(g), combinational; nothing is granted if there is no req_valid.
//     - On accept: x_q<=req_x[g]; id_q<=g; ->ISSUE.
//   ISSUE (1 cycle): sig_in_valid=1, sig_in_x=x_q, cnt<=0; ->WAIT.
//   WAIT: cnt++.
//     - sig_out_valid=1 ->CAPT.
//     - Else cnt==TIMEOUT-1 -> RESP with err_q<=1, data_q<=NAN_VAL.
//     - sig_out_valid wins if both occur in the same cycle.
//   CAPT (1 cycle): data_q<=sig_out, err_q<=0; ->RESP.
//     The unit registers its result on out_valid, so it is sampled one cycle later.
//   RESP:
//     - resp_valid=1; resp_id/resp_data/resp_err are stable until resp_ready.
//     - On resp_valid&resp_ready: last_grant<=id_q; ->IDLE.
//     - No new request is accepted before this handshake.
//   sig_in_x=x_q in ISSUE/WAIT/CAPT; 0 in IDLE/RESP.
//     The unit's out_valid mux depends on the sign of in_x, so the operand must be held.
//   sig_out_valid outside WAIT is ignored.
//   Latency accept->resp_valid = unit latency L (in_valid to out_valid) + 3 cycles.
//   Fairness: a continuously requesting port waits at most N_REQ-1 operations.
// TESTING
//   1. Real unit, req_x[0]=32'h00000000 (0.0) -> one response: id=0, data=32'h3f000000, err=0.
//   2. Mock unit, L=5; all 4 ports request continuously ->
//      grant order 0,1,2,3,0; each resp_valid 8 cycles after its accept.
//   3. resp_ready held 0 for 10 cycles in RESP ->
//      resp_* stable; req_ready=0; sig_in_valid not pulsed.
//   4. Mock never raises out_valid, TIMEOUT=64 ->
//      resp_valid 65 cycles after ISSUE, data=32'h7fc00000, err=1; next grant proceeds.
//   5. rst_l pulled low mid-WAIT (asynchronous, off clock edge) ->
//      all outputs 0 immediately; after release, IDLE with grant from port 0.
//   6. Negative x=32'hbf800000 (-1.0), mock sign-muxed out_valid ->
//      sig_in_x stable through CAPT; result captured; id correct.

Source files
------------

// File: rtl/sigmoid_rr_scheduler.sv
// Round-robin front end that shares one iterative sigmoid unit between N_REQ
// requesters. One operation in flight; the operand is held on sig_in_x until
// the result is captured. A watchdog returns NAN_VAL with resp_err if the unit
// never answers.
//
// state | meaning
// IDLE  | arbitrate, accept one request
// ISSUE | pulse sig_in_valid, clear watchdog
// WAIT  | wait for sig_out_valid or watchdog expiry
// CAPT  | sample the unit's registered result
// RESP  | present tagged result until resp_ready
module sigmoid_rr_scheduler #(
  parameter int          N_REQ      = 4,
  parameter int          exp_width  = 8,
  parameter int          mant_width = 24,
  parameter int          TIMEOUT    = 64,
  parameter logic [31:0] NAN_VAL    = 32'h7fc00000,
  localparam int         W          = exp_width + mant_width,
  localparam int         IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_x,
  output logic [N_REQ-1:0]   req_ready,
  output logic               resp_valid,
  output logic [IDW-1:0]     resp_id,
  output logic [W-1:0]       resp_data,
  output logic               resp_err,
  input  logic               resp_ready,
  output logic [W-1:0]       sig_in_x,
  output logic               sig_in_valid,
  input  logic [W-1:0]       sig_out,
  input  logic               sig_out_valid
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPT, S_RESP} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [IDW-1:0]   r_last_grant;
  logic [CW-1:0]    r_cnt;
  logic [W-1:0]     r_x_q;
  logic [IDW-1:0]   r_id_q;
  logic [W-1:0]     r_data_q;
  logic             r_err_q;

  logic             w_found;
  logic [IDW-1:0]   w_gidx;
  logic [IDW-1:0]   w_cand;
  logic [N_REQ-1:0] w_gnt;
  logic             w_timeout;

  // Round-robin search from last_grant+1; descending loop so the nearest requester wins.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = IDW'((int'(r_last_grant) + k) % N_REQ);
      if (req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gidx  = w_cand;
      end
    end
  end

  assign w_gnt     = w_found ? (N_REQ'(1) << w_gidx) : '0;
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; a result arriving on the last watchdog cycle still wins.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT: begin
        if (sig_out_valid)  w_next_state = S_CAPT;
        else if (w_timeout) w_next_state = S_RESP;
      end
      S_CAPT:  w_next_state = S_RESP;
      S_RESP:  if (resp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand, tag, watchdog and result registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_last_grant <= IDW'(N_REQ - 1);
      r_cnt        <= '0;
      r_x_q        <= '0;
      r_id_q       <= '0;
      r_data_q     <= '0;
      r_err_q      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_x_q  <= req_x[int'(w_gidx)*W +: W];
            r_id_q <= w_gidx;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (!sig_out_valid && w_timeout) begin
            r_err_q  <= 1'b1;
            r_data_q <= W'(NAN_VAL);
          end
        end
        // The unit latches its result on out_valid, so it is valid one cycle later.
        S_CAPT: begin
          r_data_q <= sig_out;
          r_err_q  <= 1'b0;
        end
        S_RESP: if (resp_ready) r_last_grant <= r_id_q;
        default: ;
      endcase
    end
  end

  // req_ready is forced low while reset is asserted so every output reads 0 in reset.
  assign req_ready    = (r_state == S_IDLE && rst_l) ? w_gnt : '0;
  assign resp_valid   = (r_state == S_RESP);
  assign resp_id      = (r_state == S_RESP) ? r_id_q   : '0;
  assign resp_data    = (r_state == S_RESP) ? r_data_q : '0;
  assign resp_err     = (r_state == S_RESP) ? r_err_q  : 1'b0;
  assign sig_in_valid = (r_state == S_ISSUE);
  // The unit's out_valid depends on the sign of in_x, so the operand is held until capture.
  assign sig_in_x     = (r_state == S_ISSUE || r_state == S_WAIT || r_state == S_CAPT) ? r_x_q : '0;

endmodule

// File: tb/tb_sigmoid_rr_scheduler.sv
// Bench for sigmoid_rr_scheduler with a behavioural mock of the sigmoid unit
// (latency 5 for positive operands, 3 for negative, optional hang).
module tb_sigmoid_rr_scheduler;
  localparam int N = 4;
  localparam int W = 32;
  localparam int L_POS = 5;
  localparam int L_NEG = 3;

  logic           clk = 1'b0;
  logic           rst_l = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_x = '0;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_data;
  logic           resp_err;
  logic           resp_ready = 1'b0;
  logic [W-1:0]   sig_in_x;
  logic           sig_in_valid;
  logic [W-1:0]   sig_out;
  logic           sig_out_valid;

  logic           m_hang = 1'b0;
  logic [3:0]     m_cnt;

  always #5 clk = ~clk;

  sigmoid_rr_scheduler #(
    .N_REQ(N), .exp_width(8), .mant_width(24), .TIMEOUT(64), .NAN_VAL(32'h7fc00000)
  ) dut (
    .clk(clk), .rst_l(rst_l), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .resp_ready(resp_ready), .sig_in_x(sig_in_x), .sig_in_valid(sig_in_valid),
    .sig_out(sig_out), .sig_out_valid(sig_out_valid)
  );

  function automatic logic [31:0] unit_f(input logic [31:0] x);
    return (x == 32'h0) ? 32'h3f000000 : (x ^ 32'h0f0f0f0f);
  endfunction

  // Mock unit: out_valid latency selected by the current sign of in_x; result registered on out_valid.
  assign sig_out_valid = !m_hang && (m_cnt != 4'd0) &&
                         (m_cnt == (sig_in_x[31] ? 4'(L_NEG) : 4'(L_POS)));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m_cnt   <= '0;
      sig_out <= '0;
    end else begin
      if (sig_in_valid)                     m_cnt <= 4'd1;
      else if (sig_out_valid)               m_cnt <= 4'd0;
      else if (m_cnt != 0 && m_cnt != 4'hf) m_cnt <= m_cnt + 4'd1;
      if (sig_out_valid) sig_out <= unit_f(sig_in_x);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] op_of(input logic [31:0] x, input int id);
    return x + 32'(id) * 32'h100;
  endfunction

  task automatic set_ops(input logic [31:0] x);
    for (int i = 0; i < N; i++) req_x[i*W +: W] = op_of(x, i);
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic wait_resp(output int n);
    n = 1;
    @(negedge clk);
    while (!resp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic finish_resp();
    @(posedge clk); #1 resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    req_valid = '0; resp_ready = 1'b0; m_hang = 1'b0;
    #1 rst_l = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_l = 1'b1;
  endtask

  task automatic run_op(input string name, input logic [3:0] mask, input logic [31:0] x,
                        input int exp_id, input int exp_lat);
    logic [31:0] op;
    int n;
    op = op_of(x, exp_id);
    @(posedge clk); #1;
    req_valid = mask; set_ops(x); resp_ready = 1'b0;
    @(negedge clk);
    check({name, " req_ready"}, 128'(req_ready), 128'(4'b0001 << exp_id));
    @(posedge clk); #1 req_valid = '0;
    wait_resp(n);
    check({name, " latency"}, 128'(n), 128'(exp_lat));
    check({name, " resp"}, {resp_valid, resp_id, resp_data, resp_err},
          {1'b1, 2'(exp_id), unit_f(op), 1'b0});
    finish_resp();
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] x;
    int          exp_id;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    int nresp;
    int acc_id[$];
    int acc_cyc[$];
    int exp_order[5];
    logic [31:0] op;

    vecs[0] = '{4'b0001, 32'h00000000, 0, 8};
    vecs[1] = '{4'b1111, 32'h40000000, 1, 8};
    vecs[2] = '{4'b1001, 32'h3f800000, 3, 8};
    vecs[3] = '{4'b0110, 32'hbf800000, 1, 6};
    vecs[4] = '{4'b0011, 32'h40490fdb, 0, 8};
    vecs[5] = '{4'b0001, 32'hc0000000, 0, 6};
    vecs[6] = '{4'b1000, 32'h00000000, 3, 8};
    vecs[7] = '{4'b0100, 32'h41200000, 2, 8};
    exp_order = '{0, 1, 2, 3, 0};

    // Reset values, with requests pending so req_ready gating is visible.
    req_valid = 4'hf; set_ops(32'h40000000);
    #1 rst_l = 1'b0;
    #2;
    check("reset outputs", {req_ready, resp_valid, resp_id, resp_data, resp_err, sig_in_x, sig_in_valid}, '0);
    do_reset();

    // Table: arbitration from varied last_grant, zero operand, negative operands.
    for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), vecs[i].mask, vecs[i].x,
                                      vecs[i].exp_id, vecs[i].exp_lat);

    // All ports requesting continuously: order 0,1,2,3,0 with 8-cycle latency.
    do_reset();
    @(posedge clk); #1;
    req_valid = 4'hf; resp_ready = 1'b1; set_ops(32'h40000000);
    nresp = 0;
    for (int c = 0; c < 80 && nresp < 5; c++) begin
      @(negedge clk);
      if (|req_ready) begin
        acc_id.push_back(oh_idx(req_ready));
        acc_cyc.push_back(c);
      end
      if (resp_valid && nresp < acc_id.size()) begin
        check($sformatf("rr order %0d", nresp), 128'(resp_id), 128'(exp_order[nresp]));
        check($sformatf("rr tag %0d", nresp), 128'(resp_id), 128'(acc_id[nresp]));
        check($sformatf("rr latency %0d", nresp), 128'(c - acc_cyc[nresp]), 128'(8));
        nresp++;
      end
    end
    check("rr response count", 128'(nresp), 128'(5));
    @(posedge clk); #1 req_valid = '0; resp_ready = 1'b0;

    // Back-pressure in RESP: outputs stable, no accept, no issue.
    @(posedge clk); #1 req_valid = 4'b0001;
    @(posedge clk); #1 req_valid = 4'hf;
    wait_resp(n);
    check("bp latency", 128'(n), 128'(8));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp hold %0d", c),
            {resp_valid, resp_id, resp_data, resp_err, req_ready, sig_in_valid},
            {1'b1, 2'd0, unit_f(32'h40000000), 1'b0, 4'b0000, 1'b0});
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    @(negedge clk);
    check("bp next grant", 128'(req_ready), 128'(4'b0010));
    @(posedge clk); #1 req_valid = '0;
    wait_resp(n);
    check("bp next resp id", 128'(resp_id), 128'(1));
    finish_resp();

    // Watchdog: unit never answers.
    m_hang = 1'b1;
    @(posedge clk); #1 req_valid = 4'b0100;
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    check("to issue pulse", 128'(sig_in_valid), 128'(1));
    n = 0;
    while (!resp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("to latency", 128'(n), 128'(65));
    check("to resp", {resp_valid, resp_id, resp_data, resp_err}, {1'b1, 2'd2, 32'h7fc00000, 1'b1});
    finish_resp();
    m_hang = 1'b0;
    run_op("after timeout", 4'b1111, 32'h40000000, 3, 8);

    // Asynchronous reset mid-WAIT.
    run_op("pre reset", 4'b0010, 32'h40000000, 1, 8);
    @(posedge clk); #1 req_valid = 4'hf;
    @(negedge clk);
    check("pre reset grant", 128'(req_ready), 128'(4'b0100));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("wait operand", 128'(sig_in_x), 128'(op_of(32'h40000000, 2)));
    @(posedge clk); #3 rst_l = 1'b0;
    #1;
    check("async reset outputs", {req_ready, resp_valid, resp_id, resp_data, resp_err, sig_in_x, sig_in_valid}, '0);
    @(negedge clk);
    check("reset held outputs", {req_ready, resp_valid, resp_id, resp_data, resp_err, sig_in_x, sig_in_valid}, '0);
    @(posedge clk); #2 rst_l = 1'b1;
    @(negedge clk);
    check("post reset grant", 128'(req_ready), 128'(4'b0001));
    @(posedge clk); #1 req_valid = '0;
    wait_resp(n);
    check("post reset latency", 128'(n), 128'(8));
    check("post reset resp", {resp_id, resp_data, resp_err}, {2'd0, unit_f(op_of(32'h40000000, 0)), 1'b0});
    finish_resp();

    // Negative operand with sign-muxed out_valid: operand held through CAPT.
    set_ops(32'hbf800000);
    op = op_of(32'hbf800000, 2);
    @(posedge clk); #1 req_valid = 4'b0100;
    @(posedge clk); #1 req_valid = '0;
    n = 1;
    @(negedge clk);
    while (!resp_valid && n < 200) begin
      check($sformatf("neg hold c%0d", n), 128'(sig_in_x), 128'(op));
      @(negedge clk);
      n++;
    end
    check("neg latency", 128'(n), 128'(6));
    check("neg resp", {resp_id, resp_data, resp_err, sig_in_x}, {2'd2, unit_f(op), 1'b0, 32'h0});
    finish_resp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "time limit");
  end
endmodule
